// File: rtl/memory_arbiter.sv
// Single-port RAM arbiter between an instruction fetch port and a data port.
// Data requests win; every access is latched, timed out, and acknowledged by a one-cycle hit.
module memory_arbiter #(
  parameter int TIMEOUT = 15,
  parameter int TCW     = 8
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        iREN,
  input  logic [31:0] iaddr,
  output logic        ihit,
  output logic [31:0] iload,
  input  logic        dREN,
  input  logic        dWEN,
  input  logic [31:0] daddr,
  input  logic [31:0] dstore,
  output logic        dhit,
  output logic [31:0] dload,
  output logic        ramREN,
  output logic        ramWEN,
  output logic [31:0] ramaddr,
  output logic [31:0] ramstore,
  input  logic [31:0] ramload,
  input  logic        ram_ready,
  output logic        err
);

  typedef enum logic [2:0] {IDLE, IACC, DACC, HIT, ERR} state_t;

  localparam logic [TCW-1:0] TMAX = TCW'(TIMEOUT);

  state_t         state, state_nxt;
  logic [31:0]    addr_q, store_q;
  logic           wsel_q;   // latched write-select for the current data access
  logic           dsel_q;   // current access belongs to the data port
  logic           held_q;   // requester kept its request up for the whole access
  logic [TCW-1:0] cnt_q;
  logic [TCW-1:0] cnt_inc;
  logic           req_now;

  assign cnt_inc  = cnt_q + TCW'(1);
  assign req_now  = dsel_q ? (dREN | dWEN) : iREN;
  assign ramaddr  = addr_q;
  assign ramstore = store_q;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // NOTE: every output of this combinational block gets a default before the case,
  // so no path leaves a signal unassigned and no latch is inferred.
  always_comb begin
    state_nxt = state;
    ramREN    = 1'b0;
    ramWEN    = 1'b0;
    ihit      = 1'b0;
    dhit      = 1'b0;
    err       = 1'b0;
    case (state)
      IDLE: begin
        if (dREN || dWEN) begin
          state_nxt = DACC;
        end else if (iREN) begin
          state_nxt = IACC;
        end
      end
      IACC, DACC: begin
        if (state == IACC) begin
          ramREN = 1'b1;
        end else begin
          ramWEN = wsel_q;
          ramREN = ~wsel_q;
        end
        if (ram_ready) begin
          state_nxt = HIT;
        end else if (cnt_inc == TMAX) begin
          state_nxt = ERR;
        end
      end
      HIT: begin
        ihit      = held_q & ~dsel_q;
        dhit      = held_q & dsel_q;
        state_nxt = IDLE;
      end
      ERR: begin
        err = 1'b1;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // NOTE: all datapath registers are cleared by reset so the RAM-side outputs and
  // load registers read zero immediately when nRST falls.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      addr_q  <= '0;
      store_q <= '0;
      wsel_q  <= 1'b0;
      dsel_q  <= 1'b0;
      held_q  <= 1'b0;
      cnt_q   <= '0;
      iload   <= '0;
      dload   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (dREN || dWEN) begin
            addr_q  <= daddr;
            store_q <= dstore;
            wsel_q  <= dWEN;
            dsel_q  <= 1'b1;
            held_q  <= 1'b1;
            cnt_q   <= '0;
          end else if (iREN) begin
            addr_q  <= iaddr;
            wsel_q  <= 1'b0;
            dsel_q  <= 1'b0;
            held_q  <= 1'b1;
            cnt_q   <= '0;
          end
        end
        IACC, DACC: begin
          // A withdrawn request still finishes on the RAM; only the hit is dropped.
          held_q <= held_q & req_now;
          if (ram_ready) begin
            if (state == IACC) begin
              iload <= ramload;
            end else if (!wsel_q) begin
              dload <= ramload;
            end
          end else begin
            cnt_q <= cnt_inc;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_memory_arbiter.sv
// Bench for memory_arbiter: table of complete accesses plus hand-built corner sequences;
// hits are matched against a scoreboard of expected completions.
module tb_memory_arbiter;

  logic        CLK = 1'b0;
  logic        nRST = 1'b1;
  logic        iREN = 1'b0;
  logic [31:0] iaddr = '0;
  logic        ihit;
  logic [31:0] iload;
  logic        dREN = 1'b0;
  logic        dWEN = 1'b0;
  logic [31:0] daddr = '0;
  logic [31:0] dstore = '0;
  logic        dhit;
  logic [31:0] dload;
  logic        ramREN;
  logic        ramWEN;
  logic [31:0] ramaddr;
  logic [31:0] ramstore;
  logic [31:0] ramload = '0;
  logic        ram_ready = 1'b0;
  logic        err;

  memory_arbiter #(.TIMEOUT(15), .TCW(8)) dut (
    .CLK(CLK), .nRST(nRST),
    .iREN(iREN), .iaddr(iaddr), .ihit(ihit), .iload(iload),
    .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore), .dhit(dhit), .dload(dload),
    .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
    .ramload(ramload), .ram_ready(ram_ready), .err(err)
  );

  always #5 CLK = ~CLK;

  typedef enum logic [1:0] {K_I, K_R, K_W, K_RW} kind_t;

  typedef struct {
    kind_t       kind;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    int          waits;
    logic [31:0] exp_load;
  } vec_t;

  typedef struct {
    logic        is_d;
    logic [31:0] load;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   total = 0;
  int   bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_ihit"}, {31'd0, ihit}, 32'd0);
    check({tag, "_dhit"}, {31'd0, dhit}, 32'd0);
    check({tag, "_iload"}, iload, 32'd0);
    check({tag, "_dload"}, dload, 32'd0);
    check({tag, "_ramREN"}, {31'd0, ramREN}, 32'd0);
    check({tag, "_ramWEN"}, {31'd0, ramWEN}, 32'd0);
    check({tag, "_ramaddr"}, ramaddr, 32'd0);
    check({tag, "_ramstore"}, ramstore, 32'd0);
    check({tag, "_err"}, {31'd0, err}, 32'd0);
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Hit monitor: every ihit/dhit must match the oldest expected completion.
  always @(negedge CLK) begin
    if (ihit || dhit) begin
      if (sb.size() == 0) begin
        check("spurious_hit", {30'd0, ihit, dhit}, 32'd0);
      end else begin
        mon_e = sb.pop_front();
        check("hit_kind", {30'd0, ihit, dhit}, mon_e.is_d ? 32'd1 : 32'd2);
        check("hit_load", mon_e.is_d ? dload : iload, mon_e.load);
      end
    end
  end

  // Called in IDLE at posedge+1; returns in IDLE at posedge+1.
  task automatic run_access(input vec_t v);
    logic is_w;
    is_w   = (v.kind == K_W) || (v.kind == K_RW);
    iREN   = (v.kind == K_I);
    dREN   = (v.kind == K_R) || (v.kind == K_RW);
    dWEN   = is_w;
    iaddr  = v.addr;
    daddr  = v.addr;
    dstore = v.wdata;
    tick();
    // Scramble requester buses: the RAM side must keep the latched values.
    iaddr  = ~v.addr;
    daddr  = ~v.addr;
    dstore = ~v.wdata;
    for (int w = 0; w <= v.waits; w++) begin
      ram_ready = (w == v.waits);
      ramload   = (w == v.waits) ? v.rdata : (32'hBAD0_0000 | w);
      check("acc_ramREN", {31'd0, ramREN}, {31'd0, ~is_w});
      check("acc_ramWEN", {31'd0, ramWEN}, {31'd0, is_w});
      check("acc_ramaddr", ramaddr, v.addr);
      if (is_w) check("acc_ramstore", ramstore, v.wdata);
      if (w == v.waits) sb.push_back('{is_d: (v.kind != K_I), load: v.exp_load});
      tick();
    end
    ram_ready = 1'b0;
    check("hit_strobes", {30'd0, ramREN, ramWEN}, 32'd0);
    iREN = 1'b0;
    dREN = 1'b0;
    dWEN = 1'b0;
    tick();
    check("idle_strobes", {30'd0, ramREN, ramWEN}, 32'd0);
  endtask

  initial begin
    #100us;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    vec_t tbl[7];
    vec_t v;
    tbl[0] = '{K_I,  32'h100, 32'h0,        32'h3C010001, 0,  32'h3C010001};
    tbl[1] = '{K_R,  32'h200, 32'h0,        32'h11112222, 1,  32'h11112222};
    tbl[2] = '{K_W,  32'h080, 32'hDEADBEEF, 32'h99999999, 3,  32'h11112222};
    tbl[3] = '{K_I,  32'h104, 32'h0,        32'hA5A5A5A5, 2,  32'hA5A5A5A5};
    tbl[4] = '{K_RW, 32'h084, 32'h01234567, 32'h88888888, 0,  32'h11112222};
    tbl[5] = '{K_R,  32'h088, 32'h0,        32'hCAFEF00D, 14, 32'hCAFEF00D};
    tbl[6] = '{K_I,  32'h000, 32'h0,        32'hFFFFFFFF, 0,  32'hFFFFFFFF};

    // Asynchronous reset, sampled before any clock edge.
    #1 nRST = 1'b0;
    #2 check_all_zero("reset");
    repeat (2) @(posedge CLK);
    @(negedge CLK) nRST = 1'b1;
    tick();

    foreach (tbl[i]) run_access(tbl[i]);

    // Data beats instruction; instruction served only after passing through IDLE.
    iREN = 1'b1; iaddr = 32'h300;
    dREN = 1'b1; daddr = 32'h200;
    tick();
    check("prio_ramREN", {31'd0, ramREN}, 32'd1);
    check("prio_ramaddr", ramaddr, 32'h200);
    ram_ready = 1'b1; ramload = 32'h5555AAAA;
    sb.push_back('{is_d: 1'b1, load: 32'h5555AAAA});
    tick();
    ram_ready = 1'b0; dREN = 1'b0;
    tick();
    check("prio_idle_gap", {30'd0, ramREN, ramWEN}, 32'd0);
    tick();
    check("prio_iacc_ramREN", {31'd0, ramREN}, 32'd1);
    check("prio_iacc_ramaddr", ramaddr, 32'h300);
    ram_ready = 1'b1; ramload = 32'h0BADF00D;
    sb.push_back('{is_d: 1'b0, load: 32'h0BADF00D});
    tick();
    ram_ready = 1'b0; iREN = 1'b0;
    tick();

    // Withdrawn data read: RAM access completes, dload updates, no dhit.
    dREN = 1'b1; daddr = 32'h40;
    tick();
    dREN = 1'b0;
    check("wd_ramREN0", {31'd0, ramREN}, 32'd1);
    tick();
    check("wd_ramREN1", {31'd0, ramREN}, 32'd1);
    check("wd_ramaddr", ramaddr, 32'h40);
    ram_ready = 1'b1; ramload = 32'h77777777;
    tick();
    ram_ready = 1'b0;
    check("wd_no_hit", {30'd0, ihit, dhit}, 32'd0);
    tick();
    check("wd_dload", dload, 32'h77777777);
    check("wd_idle", {30'd0, ramREN, ramWEN}, 32'd0);

    // Reset in the middle of a data write.
    dWEN = 1'b1; daddr = 32'h1C0; dstore = 32'h12345678;
    tick();
    tick();
    check("rstmid_ramWEN", {31'd0, ramWEN}, 32'd1);
    nRST = 1'b0;
    #1 check_all_zero("rstmid");
    dWEN = 1'b0;
    @(negedge CLK) nRST = 1'b1;
    tick();
    v = '{K_I, 32'h2A0, 32'h0, 32'h600DC0DE, 1, 32'h600DC0DE};
    run_access(v);

    // Timeout: 15 unanswered IACC cycles, then sticky err with no strobes.
    iREN = 1'b1; iaddr = 32'h500;
    tick();
    for (int k = 1; k <= 15; k++) begin
      check("to_wait_ramREN", {31'd0, ramREN}, 32'd1);
      check("to_wait_err", {31'd0, err}, 32'd0);
      tick();
    end
    dREN = 1'b1;
    for (int k = 0; k < 5; k++) begin
      check("to_err", {31'd0, err}, 32'd1);
      check("to_err_strobes", {30'd0, ramREN, ramWEN}, 32'd0);
      tick();
    end
    iREN = 1'b0; dREN = 1'b0;
    nRST = 1'b0;
    #1 check_all_zero("to_reset");
    @(negedge CLK) nRST = 1'b1;
    tick();
    v = '{K_R, 32'h3F0, 32'h0, 32'h0F0F0F0F, 0, 32'h0F0F0F0F};
    run_access(v);

    repeat (2) tick();
    check("sb_drained", sb.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/memory_arbiter.md
MEMORY_ARBITER -- requirements
Module: memory_arbiter

Interface
REQ-001 The block SHALL take parameter TIMEOUT, default 15, meaning the maximum RAM wait cycles per access before error.
REQ-002 The block SHALL take parameter TCW, default 8, meaning the timeout counter width in bits.
REQ-003 The block SHALL use one clock; reset is asynchronous and active-low.
REQ-004 CLK  input  1  system clock; all state changes on rising edge.
REQ-005 nRST  input  1  asynchronous active-low reset.
REQ-006 iREN  input  1  instruction read request, held by requester until ihit.
REQ-007 iaddr  input  32  instruction word address.
REQ-008 ihit  output  1  one-cycle pulse: iload valid.
REQ-009 iload  output  32  registered fetched instruction.
REQ-010 dREN  input  1  data read request, held until dhit.
REQ-011 dWEN  input  1  data write request, held until dhit.
REQ-012 daddr  input  32  data word address.
REQ-013 dstore  input  32  write data.
REQ-014 dhit  output  1  one-cycle pulse: data access complete, dload valid on reads.
REQ-015 dload  output  32  registered read data.
REQ-016 ramREN  output  1  RAM read strobe.
REQ-017 ramWEN  output  1  RAM write strobe.
REQ-018 ramaddr  output  32  RAM address, from latched request.
REQ-019 ramstore  output  32  RAM write data, from latched request.
REQ-020 ramload  input  32  RAM read data, valid when ram_ready.
REQ-021 ram_ready  input  1  RAM access complete this cycle.
REQ-022 err  output  1  sticky timeout error flag.

Function
REQ-023 The FSM SHALL have states IDLE, IACC, DACC, HIT, ERR.
REQ-024 In IDLE, if dREN or dWEN is high, the block SHALL latch daddr, dstore and write-select (dWEN) and go to DACC; data has priority over instruction.
REQ-025 In IDLE, if only iREN is high, the block SHALL latch iaddr and go to IACC.
REQ-026 If dREN and dWEN are both high, the access SHALL be a write (dWEN wins).
REQ-027 In IACC, ramREN SHALL be 1; in DACC, ramWEN = latched write-select and ramREN = its inverse; in all other states, ramREN = ramWEN = 0.
REQ-028 ramaddr/ramstore SHALL come only from latched values; requester input changes during an access SHALL be ignored.
REQ-029 On ram_ready in IACC/DACC, the block SHALL register ramload into iload (IACC) or dload (DACC read) and go to HIT; dload SHALL be unchanged on writes.
REQ-030 In HIT, exactly one of ihit/dhit SHALL be 1 for that single cycle, then the FSM SHALL return to IDLE.
REQ-031 Minimum latency SHALL be: request seen in IDLE at cycle 0, ram_ready in cycle 1, hit in cycle 2.
REQ-032 If the request was withdrawn before ram_ready, the access SHALL still complete on RAM, but the hit pulse SHALL be suppressed (HIT state entered, no hit).
REQ-033 A counter SHALL clear on entry to IACC/DACC and increment each cycle without ram_ready; when it reaches TIMEOUT, the FSM SHALL go to ERR.
REQ-034 In ERR, err SHALL be 1, no strobes and no hits SHALL be driven, and the FSM SHALL stay there until reset.
REQ-035 A request arriving in HIT SHALL be accepted next cycle in IDLE; there SHALL be no back-to-back grant without passing through IDLE.

Reset
REQ-036 On nRST low, the FSM SHALL go to IDLE immediately, and all outputs (ihit, dhit, iload, dload, ramREN, ramWEN, ramaddr, ramstore, err, counter) SHALL be 0.
REQ-037 Reset mid-access SHALL abandon the access with no hit generated.

Verification
REQ-038 iREN=1, iaddr=0x100, ram_ready in first IACC cycle with ramload=0x3C010001 -> ramREN=1, ramaddr=0x100 in cycle 1; ihit=1, iload=0x3C010001 in cycle 2.
REQ-039 iREN and dREN both high at IDLE, daddr=0x200 -> DACC first and dhit first; IACC follows after IDLE, then ihit.
REQ-040 dWEN=1, daddr=0x80, dstore=0xDEADBEEF, ram_ready after 3 wait cycles -> ramWEN=1, ramstore=0xDEADBEEF held for 4 cycles; dhit one cycle; dload unchanged.
REQ-041 iREN held, ram_ready never asserted, TIMEOUT=15 -> err=1 after 15 cycles in IACC, stays 1; no ihit until nRST.
REQ-042 nRST pulsed low during DACC -> all outputs 0 asynchronously, no dhit; a new iREN after release is serviced normally.
REQ-043 dREN withdrawn during DACC wait -> access completes on ram_ready, no dhit pulse, return to IDLE.
